// File: rtl/jt89_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | jt89_pkg                                                             |
// | Shared rate encodings, base periods, amplitude table and LFSR seed   |
// | helper for the PSG noise channel.                                    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package jt89_pkg;

    localparam int CNT_W      = 11;
    localparam int LFSR_MAX_W = 24;

    typedef enum logic [1:0] {
        RATE_32  = 2'd0,
        RATE_64  = 2'd1,
        RATE_128 = 2'd2,
        RATE_T2  = 2'd3
    } rate_e;

    localparam logic [CNT_W-1:0] BASE_PERIOD_32  = 11'd32;
    localparam logic [CNT_W-1:0] BASE_PERIOD_64  = 11'd64;
    localparam logic [CNT_W-1:0] BASE_PERIOD_128 = 11'd128;
    localparam logic [CNT_W-1:0] T2_MIN_PERIOD   = 11'd2;

    // 2 dB per attenuation step, last entry is mute
    localparam logic [8:0] AMP [16] = '{
        9'd511, 9'd406, 9'd322, 9'd256, 9'd203, 9'd161, 9'd128, 9'd102,
        9'd81,  9'd64,  9'd51,  9'd40,  9'd32,  9'd26,  9'd20,  9'd0
    };

    function automatic logic [LFSR_MAX_W-1:0] lfsr_seed(input int w);
        return LFSR_MAX_W'(1) << (w - 1);
    endfunction

    function automatic logic [CNT_W-1:0] jt89_reload(input logic [1:0] rate,
                                                     input logic [9:0] tone2);
        logic [CNT_W-1:0] r;
        case (rate_e'(rate))
            RATE_32:  r = BASE_PERIOD_32;
            RATE_64:  r = BASE_PERIOD_64;
            RATE_128: r = BASE_PERIOD_128;
            default:  r = (tone2 == 10'd0) ? T2_MIN_PERIOD : {tone2, 1'b0};
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/jt89_noise_gen_lfsr_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | jt89_lfsr_core                                                       |
// | Noise shift register with white/periodic feedback and zero guard.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module jt89_lfsr_core
    import jt89_pkg::*;
#(
    parameter int LFSR_W = 16,
    parameter int TAP_A  = 0,
    parameter int TAP_B  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              step,
    input  logic              seed,
    input  logic              white,
    output logic [LFSR_W-1:0] shift
);

    localparam logic [LFSR_MAX_W-1:0] C_SEED_FULL = lfsr_seed(LFSR_W);
    localparam logic [LFSR_W-1:0]     C_SEED      = C_SEED_FULL[LFSR_W-1:0];

    logic [LFSR_W-1:0] r_shift;
    logic              w_fb;
    logic [LFSR_W-1:0] w_next;

    assign w_fb = white ? (r_shift[TAP_A] ^ r_shift[TAP_B]) : r_shift[0];

    // An all-zero register would never recover, so it is reseeded instead
    assign w_next = (r_shift == '0) ? C_SEED : {w_fb, r_shift[LFSR_W-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift <= C_SEED;
        end else if (seed) begin
            r_shift <= C_SEED;
        end else if (step) begin
            r_shift <= w_next;
        end
    end

    assign shift = r_shift;

endmodule
`default_nettype wire

// File: rtl/jt89_noise_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | jt89_noise_gen                                                       |
// | PSG noise channel: rate counter, channel-2 sync, LFSR and amplitude. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module jt89_noise_gen
    import jt89_pkg::*;
#(
    parameter int LFSR_W  = 16,
    parameter int TAP_A   = 0,
    parameter int TAP_B   = 3,
    parameter int T2_SYNC = 0,
    parameter int OUT_W   = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_en,
    input  logic             wr,
    input  logic [2:0]       ctrl_in,
    input  logic [3:0]       vol,
    input  logic [9:0]       tone2,
    input  logic             tone2_out,
    output logic [OUT_W-1:0] snd,
    output logic             noise_bit,
    output logic             shift_stb
);

    localparam int C_AMP_SH = OUT_W - 9;

    logic [2:0]       r_ctrl;
    logic [CNT_W-1:0] r_cnt;
    logic             r_t2_prev;
    logic [OUT_W-1:0] r_snd;
    logic             r_noise_bit;
    logic             r_shift_stb;

    logic [LFSR_W-1:0] w_shift;
    logic              w_t2_mode;
    logic              w_expire;
    logic              w_t2_edge;
    logic              w_step;
    logic [OUT_W-1:0]  w_amp;

    // In synced rate 3 the counter is idle and tone-2 edges clock the LFSR
    assign w_t2_mode = (T2_SYNC != 0) && (r_ctrl[1:0] == RATE_T2);
    assign w_expire  = clk_en && !w_t2_mode && (r_cnt == CNT_W'(1));
    assign w_t2_edge = clk_en && w_t2_mode && tone2_out && !r_t2_prev;
    assign w_step    = (w_expire || w_t2_edge) && !wr;
    assign w_amp     = OUT_W'(AMP[vol]) << C_AMP_SH;

    jt89_lfsr_core #(
        .LFSR_W (LFSR_W),
        .TAP_A  (TAP_A),
        .TAP_B  (TAP_B)
    ) u_core (
        .clk   (clk),
        .rst   (rst),
        .step  (w_step),
        .seed  (wr),
        .white (r_ctrl[2]),
        .shift (w_shift)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ctrl      <= 3'b100;
            r_cnt       <= BASE_PERIOD_32;
            r_t2_prev   <= 1'b0;
            r_snd       <= '0;
            r_noise_bit <= 1'b0;
            r_shift_stb <= 1'b0;
        end else begin
            r_shift_stb <= w_step;

            if (wr) begin
                r_ctrl <= ctrl_in;
                r_cnt  <= jt89_reload(ctrl_in[1:0], tone2);
            end else if (clk_en && !w_t2_mode) begin
                // tone2 is only looked at here, so mid-count edits wait for reload
                r_cnt <= (r_cnt == CNT_W'(1)) ? jt89_reload(r_ctrl[1:0], tone2)
                                              : r_cnt - CNT_W'(1);
            end

            if (clk_en && w_t2_mode) begin
                r_t2_prev <= tone2_out;
            end

            if (clk_en) begin
                r_noise_bit <= w_shift[0];
                r_snd       <= w_shift[0] ? w_amp : '0;
            end
        end
    end

    assign snd       = r_snd;
    assign noise_bit = r_noise_bit;
    assign shift_stb = r_shift_stb;

endmodule
`default_nettype wire
